decoder3to8_stream: RTL and testbench
=====================================

Name: decoder3to8_stream

Overview:
- Registered 3-to-8 one-hot decoder with valid/ready handshakes on both sides. It is the inverse of the team's 8-to-3 encoder.
- Accepts a 3-bit code plus an enable bit and buffers up to two entries in a skid FIFO. Drives the decoded one-hot word downstream and counts completed output transfers.
- Used to regenerate one-hot select lines from encoded indices crossing a pipelined path.

Parameters:
- DEPTH, 2, buffer entries; fixed at 2 (skid buffer); other values unsupported.
- CNT_W, 8, width of the output-transfer counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a  input  3  encoded index.
- en  input  1  decode enable for this entry; 0 makes the entry decode to all-zero.
- in_valid  input  1  a/en valid.
- in_ready  output  1  buffer can accept.
- y  output  8  one-hot decoded word of the head entry.
- out_valid  output  1  y valid.
- out_ready  input  1  downstream accepts y.
- dec_count  output  CNT_W  number of completed output transfers, wrapping.
- sweep_start  input  1  self-test start pulse (see Optional Feature).
- sweep_busy  output  1  self-test running.

Behaviour:
- Storage:
  - 2-entry FIFO of {en, a}, with head/tail pointers and a 2-bit occupancy count (0..2).
  - in_ready = (count != 2) && !sweep_busy.
  - push = in_valid && in_ready.
  - pop = out_valid && out_ready.
- Output:
  - out_valid = (count != 0).
  - y = head.en ? (8'b1 << head.a) : 8'h00 when out_valid; y = 8'h00 when the FIFO is empty.
  - y and out_valid come from registered FIFO state only, so there is no combinational path from a/in_valid to y/out_valid.
- Latency: an entry pushed at clock edge N is visible on y/out_valid after edge N (one cycle), if the FIFO was empty.
- Throughput: one transfer per cycle sustained while out_ready=1.
- Occupancy cases:
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop in the same cycle: count unchanged; the new entry goes to the tail and the head advances.
  - count=2: in_ready=0, so no push is possible; a pop frees one slot for the following cycle.
  - count=0: out_valid=0, and out_ready is ignored.
- Data hold: while out_valid=1 and out_ready=0, y and the head entry must remain stable.
- dec_count increments by 1 on every pop, including pops of en=0 entries. It wraps from 2^CNT_W-1 to 0.
- Reset (rst_n low, asynchronous):
  - count=0, pointers=0, dec_count=0, sweep FSM=IDLE.
  - Outputs: y=8'h00, out_valid=0, sweep_busy=0, in_ready=0 while rst_n is low.
  - After reset release: in_ready=1 on the first cycle.
  - Reset asserted mid-stream discards all buffered entries; nothing buffered is emitted after release.
- a takes values 0..7 only, so it has no out-of-range case. Every enabled code yields exactly one bit set.

Optional Feature:
- Macro: DECODER_SWEEP_EN.
- With the macro defined, a two-state FSM (IDLE, RUN) is compiled in:
  - IDLE -> RUN on sweep_start=1. sweep_busy=1 in RUN.
  - In RUN, an internal 3-bit counter pushes {en=1, a=counter} whenever count!=2, starting at 0. External in_ready is forced to 0 and in_valid is ignored.
  - After code 7 is pushed: RUN -> IDLE and the counter clears to 0.
  - Output is 01,02,04,...,80 in order, subject to out_ready backpressure.
  - sweep_start is ignored while in RUN.
  - Entries already buffered when the sweep starts are emitted first, in order.
- Without the macro: sweep_start is unused, sweep_busy is tied to 0, and in_ready = (count != 2).

Test Plan:
- Single transfers: reset, then a=0..7 with en=1, one per cycle, out_ready=1 -> y=01,02,04,08,10,20,40,80, each one cycle after acceptance; dec_count=8.
- Disabled entry: a=5, en=0 -> out_valid=1 with y=00; dec_count increments by 1.
- Backpressure: out_ready=0; push a=3 then a=6 -> in_ready=0 after the second push and y holds 08. Raise out_ready -> y=08 then y=40; in_ready returns to 1 one cycle after the first pop.
- Simultaneous push/pop: count=1, in_valid=1, out_ready=1 for 10 cycles with a=i%8 -> no bubbles, count stays 1, output order matches input order.
- Reset mid-operation: two entries buffered, assert rst_n=0 asynchronously between edges -> out_valid=0, y=00, dec_count=0 immediately; after release nothing stale is emitted. Separately, 256 pops -> dec_count wraps to 0.
- DECODER_SWEEP_EN: pulse sweep_start with out_ready toggling 1/0 -> y sequence 01..80 in order, sweep_busy high until code 7 is pushed, external in_valid ignored. A second sweep_start during RUN has no effect.

Source files
------------

// File: rtl/decoder3to8_stream.sv
// decoder3to8_stream: registered 3-to-8 one-hot decoder behind a 2-entry
// skid FIFO, with valid/ready on both sides and a wrapping output-transfer
// counter.
// Optional build macro: DECODER_SWEEP_EN compiles in a self-test sweep FSM
// that pushes codes 0..7 (enabled) into the FIFO.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   a[2:0], en, in_valid  input entry and its valid; in_ready back-pressure
//   y[7:0], out_valid     decoded head entry; out_ready from downstream
//   dec_count[CNT_W-1:0]  number of completed output transfers (wraps)
//   sweep_start           self-test start pulse
//   sweep_busy            self-test running
module decoder3to8_stream #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       a,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] dec_count,
  input  logic             sweep_start,
  output logic             sweep_busy
);

  localparam int unsigned OUT_W  = 8;
  localparam int unsigned CODE_W = 3;
  localparam int unsigned ENT_W  = CODE_W + 1;
  localparam int unsigned OCC_W  = 2;

  // FIFO storage of {en, a}; pointers are one bit since depth is two
  logic [ENT_W-1:0] mem [DEPTH];
  logic             head, tail, head_n, tail_n;
  logic [OCC_W-1:0] count, count_n;
  logic             full;
  logic             push, pop, run;
  logic [ENT_W-1:0] wdata, sweep_data, head_ent;
  logic [OUT_W-1:0] y_n;
  logic             out_valid_n;

  assign full = (count == OCC_W'(DEPTH));

`ifdef DECODER_SWEEP_EN
  typedef enum logic {IDLE, RUN} state_t;
  state_t              state, state_n;
  logic [CODE_W-1:0]   scnt, scnt_n;

  // Sweep state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      scnt  <= '0;
    end else begin
      state <= state_n;
      scnt  <= scnt_n;
    end
  end

  // Sweep next-state: one code per free slot, leave RUN after code 7
  always_comb begin
    state_n = state;
    scnt_n  = scnt;
    case (state)
      IDLE: if (sweep_start) state_n = RUN;
      RUN: begin
        if (!full) begin
          scnt_n = scnt + CODE_W'(1);
          if (scnt == CODE_W'(7)) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign run        = (state == RUN);
  assign sweep_busy = run;
  assign sweep_data = {1'b1, scnt};
`else
  logic unused_sweep;
  assign unused_sweep = sweep_start;
  assign run          = 1'b0;
  assign sweep_busy   = 1'b0;
  assign sweep_data   = '0;
`endif

  // rst_n gating keeps in_ready low for the whole reset window
  assign in_ready = rst_n && !full && !run;
  assign pop      = out_valid && out_ready;

  // FIFO next-state and the decoded head word it will present
  always_comb begin
    push    = run ? !full : (in_valid && in_ready);
    wdata   = run ? sweep_data : {en, a};
    head_n  = head ^ pop;
    tail_n  = tail ^ push;
    count_n = OCC_W'(count + OCC_W'(push) - OCC_W'(pop));
    // a push landing in the next head slot bypasses the memory read
    head_ent = (push && (tail == head_n)) ? wdata : mem[head_n];
    out_valid_n = (count_n != '0);
    y_n = '0;
    if (out_valid_n && head_ent[CODE_W]) y_n = OUT_W'(1) << head_ent[CODE_W-1:0];
  end

  // Storage array is not reset; occupancy alone qualifies its contents
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= wdata;
  end

  // Pointers, occupancy, registered outputs, transfer counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= 1'b0;
      tail      <= 1'b0;
      count     <= '0;
      y         <= '0;
      out_valid <= 1'b0;
      dec_count <= '0;
    end else begin
      head      <= head_n;
      tail      <= tail_n;
      count     <= count_n;
      y         <= y_n;
      out_valid <= out_valid_n;
      if (pop) dec_count <= dec_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_decoder3to8_stream.sv
// Testbench for decoder3to8_stream: directed steps plus randomized traffic
// checked against a queue-based model of the decoder stream.
module tb_decoder3to8_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] a;
  logic       en, in_valid, in_ready;
  logic [7:0] y;
  logic       out_valid, out_ready;
  logic [7:0] dec_count;
  logic       sweep_start, sweep_busy;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] q[$];
  int         dcnt   = 0;
  int         npop   = 0;
  logic       m_busy = 1'b0;
  int         sc     = 0;

  always #5 clk = ~clk;

  decoder3to8_stream #(.DEPTH(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .en(en), .in_valid(in_valid),
    .in_ready(in_ready), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .dec_count(dec_count), .sweep_start(sweep_start), .sweep_busy(sweep_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] onehot(input logic [2:0] code, input logic ena);
    return ena ? 8'(2 ** code) : 8'h00;
  endfunction

  // One clock: check outputs at negedge, drive inputs, update model at posedge
  task automatic step(input logic iv, input logic [2:0] ia, input logic ie,
                      input logic ordy, input logic ss);
    logic exp_rdy, do_push, do_pop, s_push, busy_pre;
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("y", 32'(y), (q.size() != 0) ? 32'(q[0]) : 32'h0);
    chk("dec_count", 32'(dec_count), 32'(dcnt));
    chk("sweep_busy", 32'(sweep_busy), 32'(m_busy));
    in_valid = iv; a = ia; en = ie; out_ready = ordy; sweep_start = ss;
    #1;
    exp_rdy = (q.size() < 2) && !m_busy;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    do_push  = iv && exp_rdy;
    s_push   = m_busy && (q.size() < 2);
    do_pop   = (q.size() != 0) && ordy;
    busy_pre = m_busy;
    @(posedge clk);
    if (do_pop) begin
      void'(q.pop_front());
      dcnt = (dcnt + 1) % 256;
      npop++;
    end
    if (do_push) q.push_back(onehot(ia, ie));
    if (s_push) begin
      q.push_back(onehot(3'(sc), 1'b1));
      if (sc == 7) begin m_busy = 1'b0; sc = 0; end
      else sc++;
    end
`ifdef DECODER_SWEEP_EN
    if (ss && !busy_pre) m_busy = 1'b1;
`endif
    @(negedge clk);
  endtask

  task automatic model_reset();
    q.delete();
    dcnt = 0; npop = 0; m_busy = 1'b0; sc = 0;
  endtask

  initial begin
    rst_n = 1'b0; a = '0; en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sweep_start = 1'b0;
    repeat (2) @(negedge clk);
    // Values held during reset
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_y", 32'(y), 32'h0);
    chk("rst_dec_count", 32'(dec_count), 32'h0);
    chk("rst_sweep_busy", 32'(sweep_busy), 32'h0);
    rst_n = 1'b1;
    #1 chk("rel_in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);

    // Single transfers a=0..7
    for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    chk("dec_after8", 32'(dec_count), 32'd8);

    // Disabled entry decodes to zero but still counts
    step(1'b1, 3'd5, 1'b0, 1'b1, 1'b0);
    chk("dis_valid", 32'(out_valid), 32'h1);
    chk("dis_y", 32'(y), 32'h0);
    step(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    chk("dis_count", 32'(dec_count), 32'd9);

    // Backpressure: fill, hold, then drain
    step(1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'd6, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
    chk("bp_hold_y", 32'(y), 32'h08);
    step(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    chk("bp_second_y", 32'(y), 32'h40);
    step(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);

    // Simultaneous push/pop at occupancy 1
    step(1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) step(1'b1, 3'(i % 8), 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 300; i++)
      step(1'($urandom), 3'($urandom), 1'($urandom_range(3) != 0),
           1'($urandom), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset with two entries buffered
    step(1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'd7, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_out_valid", 32'(out_valid), 32'h0);
    chk("mid_y", 32'(y), 32'h0);
    chk("mid_dec_count", 32'(dec_count), 32'h0);
    chk("mid_in_ready", 32'(in_ready), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("mid_rel_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);

    // Counter wrap after 256 pops
    for (int i = 0; i < 300 && npop < 256; i++) step(1'b1, 3'(i), 1'b1, 1'b1, 1'b0);
    chk("wrap_npop", 32'(npop), 32'd256);
    chk("wrap_dec", 32'(dec_count), 32'h0);
    for (int i = 0; i < 2; i++) step(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);

`ifdef DECODER_SWEEP_EN
    // Sweep with one entry pre-buffered and toggling out_ready
    step(1'b1, 3'd4, 1'b1, 1'b0, 1'b0);
    step(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    chk("sweep_started", 32'(sweep_busy), 32'h1);
    for (int i = 0; i < 60 && (m_busy || q.size() != 0); i++)
      step(m_busy, 3'($urandom), 1'b1, 1'(i % 2), 1'(i == 3));
    chk("sweep_done", 32'(sweep_busy), 32'h0);
    chk("sweep_drained", 32'(q.size()), 32'h0);
`endif
    step(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
